cflow_log_writer: RTL

// - Parametrised successor to the single-pointer CF-Log path. Takes branch events (src,dest) from the branch monitor.
// - Run-length compresses repeated identical pairs (loops) into one tagged loop record.
// - Buffers records in a small FIFO and writes them to the CF-Log memory through a ready/valid write port.
// - Raises a flush request at a watermark or at ER exit, and waits for the attestation side to acknowledge it.

---
 rtl/cflow_log_writer_pkg.sv | 19 +
 rtl/cflow_log_fifo.sv | 59 +++++
 rtl/cflow_log_writer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cflow_log_writer_pkg.sv
// Shared definitions for the CF-Log writer: writer FSM encodings, loop tag
// default and the record width helper.
package cflow_log_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_SRC = 2'd1,
    ST_WR_DST = 2'd2,
    ST_FLUSH  = 2'd3
  } wr_state_t;

  localparam logic [15:0] LOOP_TAG_DEFAULT = 16'hFFFF;

  // One record is a {src,dest} pair, each DATA_W bits wide.
  function automatic int rec_width(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/cflow_log_fifo.sv
// Synchronous record FIFO; a push while full is accepted only if a pop frees
// a slot in the same cycle.
module cflow_log_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      used;
  logic             do_push;
  logic             do_pop;

  assign empty   = (used == '0);
  assign full    = (used == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   used <= used + (AW+1)'(1);
        2'b01:   used <= used - (AW+1)'(1);
        default: used <= used;
      endcase
    end
  end

endmodule

// File: rtl/cflow_log_writer.sv
// Control-flow log writer: run-length compresses branch pairs into records,
// buffers them and writes them word by word into the CF-Log with flush control.
module cflow_log_writer
  import cflow_log_writer_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                LOG_WORDS  = 256,
  parameter int                HEADROOM   = 4,
  parameter int                FIFO_DEPTH = 4,
  parameter int                CNT_W      = 16,
  parameter logic [DATA_W-1:0] LOOP_TAG   = DATA_W'(LOOP_TAG_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [DATA_W-1:0] br_src,
  input  logic [DATA_W-1:0] br_dest,
  input  logic              er_done,
  output logic              mem_wr_en,
  input  logic              mem_wr_ready,
  output logic [DATA_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [DATA_W-1:0] log_ptr,
  output logic              flush_req,
  input  logic              flush_ack,
  output logic              overflow
);

  localparam int                REC_W     = rec_width(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [DATA_W-1:0] WATERMARK = DATA_W'(LOG_WORDS - HEADROOM);

  wr_state_t         state;
  wr_state_t         state_n;
  logic [DATA_W-1:0] ptr_n;
  logic [DATA_W-1:0] ptr_inc;

  logic [DATA_W-1:0] last_src;
  logic [DATA_W-1:0] last_dest;
  logic              last_valid;
  logic [DATA_W-1:0] hold_src;
  logic [DATA_W-1:0] hold_dest;
  logic              hold_valid;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_n;
  logic [CNT_W-1:0]  cnt_inc;
  logic              flush_pending;

  logic              accept;
  logic              same_pair;
  logic              hold_set;
  logic              push;
  logic [REC_W-1:0]  push_data;
  logic              pop;
  logic [REC_W-1:0]  fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  // The cycle after a loop record is emitted the held pair owns the push slot.
  assign br_ready  = !hold_valid;
  assign accept    = enable && br_valid && br_ready;
  assign same_pair = last_valid && (br_src == last_src) && (br_dest == last_dest);
  assign cnt_inc   = count + CNT_W'(1);

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    count_n   = count;
    hold_set  = 1'b0;
    if (hold_valid) begin
      push      = 1'b1;
      push_data = {hold_src, hold_dest};
    end else if (accept) begin
      if (same_pair) begin
        if (er_done || cnt_inc == CNT_MAX) begin
          push      = 1'b1;
          push_data = {LOOP_TAG, DATA_W'(cnt_inc)};
          count_n   = '0;
        end else begin
          count_n = cnt_inc;
        end
      end else if (count != '0) begin
        push      = 1'b1;
        push_data = {LOOP_TAG, DATA_W'(count)};
        count_n   = '0;
        hold_set  = 1'b1;
      end else begin
        push      = 1'b1;
        push_data = {br_src, br_dest};
      end
    end else if (er_done && count != '0) begin
      push      = 1'b1;
      push_data = {LOOP_TAG, DATA_W'(count)};
      count_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_src      <= '0;
      last_dest     <= '0;
      last_valid    <= 1'b0;
      hold_src      <= '0;
      hold_dest     <= '0;
      hold_valid    <= 1'b0;
      count         <= '0;
      flush_pending <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      count <= count_n;
      if (hold_set) begin
        hold_valid <= 1'b1;
        hold_src   <= br_src;
        hold_dest  <= br_dest;
      end else begin
        hold_valid <= 1'b0;
      end
      if (accept) begin
        last_src  <= br_src;
        last_dest <= br_dest;
      end
      if (er_done) begin
        last_valid <= 1'b0;
      end else if (accept) begin
        last_valid <= 1'b1;
      end
      if (er_done) begin
        flush_pending <= 1'b1;
      end else if (state == ST_FLUSH && flush_ack) begin
        flush_pending <= 1'b0;
      end
      // A record is lost only when no slot is free even after this cycle's pop.
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  cflow_log_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ptr_inc = log_ptr + DATA_W'(1);

  always_comb begin
    state_n = state;
    ptr_n   = log_ptr;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_n = ST_WR_SRC;
        end else if (flush_pending) begin
          state_n = ST_FLUSH;
        end
      end
      ST_WR_SRC: begin
        if (mem_wr_ready) begin
          ptr_n   = ptr_inc;
          state_n = ST_WR_DST;
        end
      end
      ST_WR_DST: begin
        if (mem_wr_ready) begin
          ptr_n   = ptr_inc;
          pop     = 1'b1;
          state_n = (ptr_inc >= WATERMARK) ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_ack) begin
          ptr_n   = '0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      log_ptr <= '0;
    end else begin
      state   <= state_n;
      log_ptr <= ptr_n;
    end
  end

  assign mem_wr_en   = (state == ST_WR_SRC) || (state == ST_WR_DST);
  assign mem_wr_addr = log_ptr;
  assign flush_req   = (state == ST_FLUSH);

  always_comb begin
    mem_wr_data = '0;
    if (state == ST_WR_SRC) begin
      mem_wr_data = fifo_dout[REC_W-1 -: DATA_W];
    end else if (state == ST_WR_DST) begin
      mem_wr_data = fifo_dout[DATA_W-1:0];
    end
  end

endmodule
